// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter
// Round-robin write scheduler for one shared WIDTH-bit register. At most one
// requester is granted per cycle and its data is captured into the register.
// A granted requester holding lock keeps the register for a burst of up to
// MAX_HOLD consecutive writes; on release, arbitration happens at the same edge.
module dff_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           lock,
  input  logic [N_REQ*WIDTH-1:0]     wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [PW-1:0]     ptr_reg, ptr_next;
  logic [HW-1:0]     hold_cnt_reg, hold_cnt_next;
  logic [N_REQ-1:0]  gnt_reg, gnt_next;
  logic [WIDTH-1:0]  q_reg, q_next;
  logic              q_valid_reg, q_valid_next;
  logic [PW-1:0]     owner_reg, owner_next;

  logic [WIDTH-1:0]  wdata_arr [N_REQ];
  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     scan_idx;
  logic              burst_continue;

  // Split the flat write-data bus into one word per requester.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Next index in round-robin order, wrapping from N_REQ-1 back to 0.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (v == PW'(N_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // Round-robin scan: first active request starting at ptr and wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = ptr_reg;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  // The owner keeps the register while it still requests with lock and the
  // burst has not yet reached MAX_HOLD writes.
  assign burst_continue = (state_reg == OWN) && req[owner_reg] && lock[owner_reg]
                          && (hold_cnt_reg < HW'(MAX_HOLD));

  // Next-state and next-output selection: continue burst, or arbitrate.
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    gnt_next      = gnt_reg;
    q_next        = q_reg;
    q_valid_next  = q_valid_reg;
    owner_next    = owner_reg;
    if (burst_continue) begin
      q_next        = wdata_arr[owner_reg];
      q_valid_next  = 1'b1;
      hold_cnt_next = hold_cnt_reg + 1'b1;
    end else if (win_found) begin
      // Fresh grant; ptr moves past the winner so it gets lowest priority next.
      gnt_next      = N_REQ'(1) << win_idx;
      q_next        = wdata_arr[win_idx];
      q_valid_next  = 1'b1;
      owner_next    = win_idx;
      ptr_next      = wrap_inc(win_idx);
      hold_cnt_next = HW'(1);
      state_next    = (lock[win_idx] && (MAX_HOLD > 1)) ? OWN : IDLE;
    end else begin
      // Nobody requesting: drop the grant, keep the stored data and owner.
      gnt_next      = '0;
      q_valid_next  = 1'b0;
      state_next    = IDLE;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      gnt_reg      <= '0;
      q_reg        <= '0;
      q_valid_reg  <= 1'b0;
      owner_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      gnt_reg      <= gnt_next;
      q_reg        <= q_next;
      q_valid_reg  <= q_valid_next;
      owner_reg    <= owner_next;
    end
  end

  assign gnt     = gnt_reg;
  assign q       = q_reg;
  assign q_valid = q_valid_reg;
  assign owner   = owner_reg;
  assign busy    = (state_reg == OWN);

endmodule
